rtc_calendar_counter: RTL and testbench

Binary timekeeping core of the millennium clock. Divides the system clock down to a 1 Hz advance and maintains seconds, minutes, hours, day, month and year with Gregorian leap-year handling. Accepts a validated time/date load from the settings logic. Its binary outputs feed bin_to_bcd directly, with matching widths and field names.

---
 rtl/rtc_calendar_counter.sv | 121 ++++++++++++
 tb/tb_rtc_calendar_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_calendar_counter.sv
// rtl/rtc_calendar_counter.sv - 1 Hz prescaler and Gregorian time/date counter with validated load
module rtc_calendar_counter #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int YEAR_MIN = 2000,
   parameter int YEAR_MAX = 2999
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        load,
   input  logic [5:0]  set_sec,
   input  logic [5:0]  set_min,
   input  logic [4:0]  set_hour,
   input  logic [4:0]  set_day,
   input  logic [3:0]  set_month,
   input  logic [11:0] set_year,
   output logic [5:0]  sec_bin,
   output logic [5:0]  min_bin,
   output logic [4:0]  hour_bin,
   output logic [4:0]  day_bin,
   output logic [3:0]  month_bin,
   output logic [11:0] year_bin,
   output logic        tick_1hz,
   output logic        set_ok,
   output logic        set_err
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
   localparam logic [11:0]   Y_MIN  = 12'(YEAR_MIN);
   localparam logic [11:0]   Y_MAX  = 12'(YEAR_MAX);

   function automatic logic is_leap(input logic [11:0] y);
      return (y[1:0] == 2'd0) &&
             (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
   endfunction

   function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [11:0] y);
      logic [4:0] d;
      case (m)
         4'd2:                     d = is_leap(y) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:  d = 5'd30;
         default:                  d = 5'd31;
      endcase
      return d;
   endfunction

   logic [PW-1:0] presc;
   logic          term;
   logic          load_valid;
   logic          c_sec, c_min, c_hour, c_day, c_month;
   logic [5:0]    nxt_sec, nxt_min;
   logic [4:0]    nxt_hour, nxt_day;
   logic [3:0]    nxt_month;
   logic [11:0]   nxt_year;

   assign term = (presc == PRE_TC);

   assign load_valid = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23) &&
                       (set_month >= 4'd1) && (set_month <= 4'd12) &&
                       (set_day >= 5'd1) && (set_day <= days_in_month(set_month, set_year)) &&
                       (set_year >= Y_MIN) && (set_year <= Y_MAX);

   // Carry chain: each field wraps only when every lower field wraps in the same advance.
   assign c_sec   = (sec_bin == 6'd59);
   assign c_min   = c_sec && (min_bin == 6'd59);
   assign c_hour  = c_min && (hour_bin == 5'd23);
   assign c_day   = c_hour && (day_bin == days_in_month(month_bin, year_bin));
   assign c_month = c_day && (month_bin == 4'd12);

   assign nxt_sec   = c_sec ? 6'd0 : sec_bin + 6'd1;
   assign nxt_min   = c_sec ? (c_min ? 6'd0 : min_bin + 6'd1) : min_bin;
   assign nxt_hour  = c_min ? (c_hour ? 5'd0 : hour_bin + 5'd1) : hour_bin;
   assign nxt_day   = c_hour ? (c_day ? 5'd1 : day_bin + 5'd1) : day_bin;
   assign nxt_month = c_day ? (c_month ? 4'd1 : month_bin + 4'd1) : month_bin;
   assign nxt_year  = c_month ? ((year_bin == Y_MAX) ? Y_MIN : year_bin + 12'd1) : year_bin;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc     <= '0;
         sec_bin   <= 6'd0;
         min_bin   <= 6'd0;
         hour_bin  <= 5'd0;
         day_bin   <= 5'd1;
         month_bin <= 4'd1;
         year_bin  <= Y_MIN;
         tick_1hz  <= 1'b0;
         set_ok    <= 1'b0;
         set_err   <= 1'b0;
      end else begin
         tick_1hz <= 1'b0;
         set_ok   <= 1'b0;
         set_err  <= load & ~load_valid;
         // A valid load overrides any advance due on the same edge.
         if (load && load_valid) begin
            presc     <= '0;
            sec_bin   <= set_sec;
            min_bin   <= set_min;
            hour_bin  <= set_hour;
            day_bin   <= set_day;
            month_bin <= set_month;
            year_bin  <= set_year;
            set_ok    <= 1'b1;
         end else if (run) begin
            if (term) begin
               presc     <= '0;
               tick_1hz  <= 1'b1;
               sec_bin   <= nxt_sec;
               min_bin   <= nxt_min;
               hour_bin  <= nxt_hour;
               day_bin   <= nxt_day;
               month_bin <= nxt_month;
               year_bin  <= nxt_year;
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// tb/tb_rtc_calendar_counter.sv - directed and randomized check of rtc_calendar_counter against a calendar model
module tb_rtc_calendar_counter;

   localparam int HZ = 4;
   localparam int MLEN [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        load = 1'b0;
   logic [5:0]  set_sec = '0, set_min = '0;
   logic [4:0]  set_hour = '0, set_day = '0;
   logic [3:0]  set_month = '0;
   logic [11:0] set_year = '0;
   logic [5:0]  sec_bin, min_bin;
   logic [4:0]  hour_bin, day_bin;
   logic [3:0]  month_bin;
   logic [11:0] year_bin;
   logic        tick_1hz, set_ok, set_err;

   int n_assert = 0;
   int n_fail   = 0;
   int m_sec, m_min, m_hour, m_day, m_month, m_year, m_pre;
   bit m_tick, m_ok, m_err;
   string step_tag = "reset";

   rtc_calendar_counter #(.CLK_HZ(HZ), .YEAR_MIN(2000), .YEAR_MAX(2999)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .load(load),
      .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
      .set_day(set_day), .set_month(set_month), .set_year(set_year),
      .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin),
      .day_bin(day_bin), .month_bin(month_bin), .year_bin(year_bin),
      .tick_1hz(tick_1hz), .set_ok(set_ok), .set_err(set_err)
   );

   always #5 clk = ~clk;

   function automatic int tb_dim(int m, int y);
      bit leap;
      leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
      if (m < 1 || m > 12) return 0;
      return (m == 2 && leap) ? 29 : MLEN[m-1];
   endfunction

   // Model advance: time of day as a seconds count, date as day/month/year arithmetic.
   task automatic model_advance();
      int sod;
      sod = m_hour * 3600 + m_min * 60 + m_sec + 1;
      if (sod == 86400) begin
         sod = 0;
         m_day++;
         if (m_day > tb_dim(m_month, m_year)) begin
            m_day = 1;
            m_month++;
            if (m_month > 12) begin
               m_month = 1;
               m_year++;
               if (m_year > 2999) m_year = 2000;
            end
         end
      end
      m_hour = sod / 3600;
      m_min  = (sod / 60) % 60;
      m_sec  = sod % 60;
   endtask

   task automatic model_step();
      bit valid;
      m_tick = 0; m_ok = 0; m_err = 0;
      if (!rst_n) begin
         m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_month = 1; m_year = 2000; m_pre = 0;
         return;
      end
      valid = (int'(set_sec) <= 59) && (int'(set_min) <= 59) && (int'(set_hour) <= 23) &&
              (int'(set_day) >= 1) && (int'(set_day) <= tb_dim(int'(set_month), int'(set_year))) &&
              (int'(set_year) >= 2000) && (int'(set_year) <= 2999);
      if (load && valid) begin
         m_sec = int'(set_sec); m_min = int'(set_min); m_hour = int'(set_hour);
         m_day = int'(set_day); m_month = int'(set_month); m_year = int'(set_year);
         m_pre = 0; m_ok = 1;
      end else begin
         if (load) m_err = 1;
         if (run) begin
            if (m_pre == HZ - 1) begin
               m_pre = 0; m_tick = 1;
               model_advance();
            end else begin
               m_pre++;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      n_assert++;
      assert (got === 32'(exp)) else begin
         n_fail++;
         $error("FAIL %s [%s]: observed %0d expected %0d", tag, step_tag, got, exp);
      end
   endtask

   task automatic check_model();
      chk("sec", 32'(sec_bin), m_sec);
      chk("min", 32'(min_bin), m_min);
      chk("hour", 32'(hour_bin), m_hour);
      chk("day", 32'(day_bin), m_day);
      chk("month", 32'(month_bin), m_month);
      chk("year", 32'(year_bin), m_year);
      chk("tick", 32'(tick_1hz), int'(m_tick));
      chk("set_ok", 32'(set_ok), int'(m_ok));
      chk("set_err", 32'(set_err), int'(m_err));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic do_load(input int h, input int mi, input int s, input int d, input int mo, input int y);
      set_hour = 5'(h); set_min = 6'(mi); set_sec = 6'(s);
      set_day = 5'(d); set_month = 4'(mo); set_year = 12'(y);
      load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic load_tick(input int h, input int mi, input int s, input int d, input int mo, input int y);
      do_load(h, mi, s, d, mo, y);
      chk("load_ok", 32'(set_ok), 1);
      repeat (HZ) cyc();
      chk("load_tick", 32'(tick_1hz), 1);
   endtask

   task automatic chk_date(input int d, input int mo, input int y);
      chk("date_day", 32'(day_bin), d);
      chk("date_month", 32'(month_bin), mo);
      chk("date_year", 32'(year_bin), y);
   endtask

   initial begin
      cyc();
      chk("rst_sec", 32'(sec_bin), 0);
      chk("rst_tick", 32'(tick_1hz), 0);
      chk_date(1, 1, 2000);

      step_tag = "basic";
      rst_n = 1'b1; run = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         chk("first_tick", 32'(tick_1hz), (i == 4) ? 1 : 0);
      end
      repeat (236) cyc();
      chk("one_min_min", 32'(min_bin), 1);
      chk("one_min_sec", 32'(sec_bin), 0);

      step_tag = "ripple";
      load_tick(23, 59, 59, 31, 12, 2999);
      chk("ripple_hour", 32'(hour_bin), 0);
      chk_date(1, 1, 2000);
      load_tick(23, 59, 59, 31, 12, 2000);
      chk_date(1, 1, 2001);

      step_tag = "leap";
      load_tick(23, 59, 59, 28, 2, 2024); chk_date(29, 2, 2024);
      load_tick(23, 59, 59, 28, 2, 2100); chk_date(1, 3, 2100);
      load_tick(23, 59, 59, 28, 2, 2000); chk_date(29, 2, 2000);
      load_tick(23, 59, 59, 29, 2, 2024); chk_date(1, 3, 2024);

      step_tag = "validate";
      do_load(0, 0, 0, 29, 2, 2023);  chk("err_feb29", 32'(set_err), 1);
      do_load(0, 0, 0, 31, 4, 2024);  chk("err_apr31", 32'(set_err), 1);
      do_load(24, 0, 0, 1, 1, 2024);  chk("err_h24", 32'(set_err), 1);
      do_load(0, 0, 0, 1, 1, 1999);   chk("err_y1999", 32'(set_err), 1);
      do_load(0, 0, 0, 29, 2, 2400);  chk("ok_2400", 32'(set_ok), 1);

      step_tag = "collide";
      repeat (HZ - 1) cyc();
      do_load(10, 20, 30, 15, 6, 2050);
      chk("col_ok", 32'(set_ok), 1);
      chk("col_notick", 32'(tick_1hz), 0);
      chk("col_sec", 32'(sec_bin), 30);
      for (int i = 1; i <= HZ; i++) begin
         cyc();
         chk("col_next_tick", 32'(tick_1hz), (i == HZ) ? 1 : 0);
      end
      repeat (HZ - 1) cyc();
      do_load(25, 0, 0, 1, 1, 2050);
      chk("col_err", 32'(set_err), 1);
      chk("col_err_tick", 32'(tick_1hz), 1);

      step_tag = "run";
      repeat (2) cyc();
      run = 1'b0;
      repeat (10) begin
         cyc();
         chk("frozen_tick", 32'(tick_1hz), 0);
      end
      run = 1'b1;
      cyc(); chk("resume_notick", 32'(tick_1hz), 0);
      cyc(); chk("resume_tick", 32'(tick_1hz), 1);

      step_tag = "midreset";
      do_load(12, 34, 56, 10, 10, 2222);
      repeat (2) cyc();
      rst_n = 1'b0;
      cyc();
      chk("mr_hour", 32'(hour_bin), 0);
      chk("mr_min", 32'(min_bin), 0);
      chk("mr_sec", 32'(sec_bin), 0);
      chk_date(1, 1, 2000);
      rst_n = 1'b1;
      for (int i = 1; i <= HZ; i++) begin
         cyc();
         chk("mr_tick", 32'(tick_1hz), (i == HZ) ? 1 : 0);
      end

      step_tag = "random";
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         run   = ($urandom_range(0, 9) != 0);
         load  = ($urandom_range(0, 11) == 0);
         set_sec  = 6'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 63) : 59);
         set_min  = 6'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 63) : 59);
         set_hour = 5'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 31) : 23);
         set_day  = 5'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range(28, 31));
         set_month = 4'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) :
                        (($urandom_range(0, 1) == 0) ? 2 : 12));
         case ($urandom_range(0, 6))
            0: set_year = 12'd1999;
            1: set_year = 12'd3000;
            2: set_year = 12'd2999;
            3: set_year = 12'd2100;
            4: set_year = 12'd2400;
            default: set_year = 12'(2000 + $urandom_range(0, 999));
         endcase
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
